// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: decodes RISC-V load/store size and drives the data memory.
// An access that crosses a word boundary is split into two word-aligned cycles.
// Stores use read-merge-write. Loads capture the low word and then combine it with the high word.
module load_store_unit #(
    parameter int MP_WIDTH = 32
) (
    input  logic                iclk,
    input  logic                irst,
    input  logic                ivalid,
    input  logic                iload,
    input  logic                istore,
    input  logic [2:0]          ifunct3,
    input  logic [MP_WIDTH-1:0] iaddr,
    input  logic [MP_WIDTH-1:0] iwdata,
    output logic                ostall,
    output logic                odone,
    output logic                oerr,
    output logic [MP_WIDTH-1:0] odata,
    output logic [MP_WIDTH-1:0] opos,
    output logic                owen,
    output logic [1:0]          obe,
    output logic [MP_WIDTH-1:0] owdata,
    input  logic [MP_WIDTH-1:0] irdata
);

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [MP_WIDTH-1:0] rlo;
    logic                capture_lo;

    logic                is_store;
    logic                is_load;
    logic                legal;
    logic                span;
    logic [1:0]          off;
    int                  nbytes;
    int                  hi_count;
    logic [5:0]          lo_shift;
    logic [5:0]          hi_shift;
    logic [MP_WIDTH-1:0] word_base;
    logic [MP_WIDTH-1:0] word_next;
    logic [MP_WIDTH-1:0] store_shl;
    logic [MP_WIDTH-1:0] store_shr;
    logic [MP_WIDTH-1:0] merge_lo;
    logic [MP_WIDTH-1:0] merge_hi;
    logic [MP_WIDTH-1:0] single_raw;
    logic [MP_WIDTH-1:0] pair_raw;

    // Sign- or zero-extend an LSB-aligned raw load value according to funct3.
    function automatic logic [MP_WIDTH-1:0] extend(input logic [MP_WIDTH-1:0] raw,
                                                   input logic [2:0] f3);
        logic [MP_WIDTH-1:0] res;
        case (f3)
            3'b000:  res = {{24{raw[7]}}, raw[7:0]};
            3'b001:  res = {{16{raw[15]}}, raw[15:0]};
            3'b010:  res = raw;
            3'b100:  res = {24'h0, raw[7:0]};
            3'b101:  res = {16'h0, raw[15:0]};
            default: res = '0;
        endcase
        return res;
    endfunction

    // Decode the access: operation, legality, size, and whether it crosses a word boundary.
    always_comb begin
        is_store  = istore;
        is_load   = iload & ~istore;
        off       = iaddr[1:0];
        case (ifunct3[1:0])
            2'b00:   nbytes = 1;
            2'b01:   nbytes = 2;
            default: nbytes = 4;
        endcase
        if (is_store) begin
            legal = (ifunct3 == 3'b000) || (ifunct3 == 3'b001) || (ifunct3 == 3'b010);
        end else begin
            legal = (ifunct3 == 3'b000) || (ifunct3 == 3'b001) || (ifunct3 == 3'b010) ||
                    (ifunct3 == 3'b100) || (ifunct3 == 3'b101);
        end
        span      = ((nbytes == 2) && (off == 2'd3)) || ((nbytes == 4) && (off != 2'd0));
        hi_count  = int'(off) + nbytes - 4;
        lo_shift  = {1'b0, off, 3'b000};
        hi_shift  = 6'd32 - lo_shift;
        word_base = {iaddr[MP_WIDTH-1:2], 2'b00};
        word_next = {iaddr[MP_WIDTH-1:2] + 30'd1, 2'b00};
    end

    // Build the merged store words and the raw (unextended) load values byte by byte.
    always_comb begin
        store_shl  = iwdata << lo_shift;
        store_shr  = iwdata >> hi_shift;
        single_raw = irdata >> lo_shift;
        merge_lo   = irdata;
        merge_hi   = irdata;
        pair_raw   = '0;
        for (int k = 0; k < 4; k++) begin
            if (k >= int'(off)) begin
                merge_lo[8*k +: 8] = store_shl[8*k +: 8];
            end
            if (k < hi_count) begin
                merge_hi[8*k +: 8] = store_shr[8*k +: 8];
            end
            if ((int'(off) + k) < 4) begin
                pair_raw[8*k +: 8] = rlo[8*((int'(off) + k) & 3) +: 8];
            end else begin
                pair_raw[8*k +: 8] = irdata[8*((int'(off) + k) & 3) +: 8];
            end
        end
    end

    // Next-state and memory-interface outputs for the two-state split sequencer.
    always_comb begin
        ostall     = 1'b0;
        odone      = 1'b0;
        oerr       = 1'b0;
        odata      = '0;
        opos       = '0;
        owen       = 1'b0;
        obe        = 2'b00;
        owdata     = '0;
        capture_lo = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (ivalid) begin
                    if (!is_store && !is_load) begin
                        odone = 1'b1;
                    end else if (!legal) begin
                        oerr  = 1'b1;
                        odone = 1'b1;
                    end else if (!span) begin
                        odone = 1'b1;
                        opos  = iaddr;
                        obe   = ifunct3[1:0];
                        if (is_store) begin
                            owen   = 1'b1;
                            owdata = iwdata;
                        end else begin
                            odata = extend(single_raw, ifunct3);
                        end
                    end else begin
                        ostall     = 1'b1;
                        opos       = word_base;
                        obe        = 2'b10;
                        state_next = SECOND;
                        if (is_store) begin
                            owen   = 1'b1;
                            owdata = merge_lo;
                        end else begin
                            capture_lo = 1'b1;
                        end
                    end
                end
            end
            SECOND: begin
                odone      = 1'b1;
                opos       = word_next;
                obe        = 2'b10;
                state_next = IDLE;
                if (is_store) begin
                    owen   = ~irst;
                    owdata = merge_hi;
                end else if (is_load) begin
                    odata = extend(pair_raw, ifunct3);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and low-word capture for split loads.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state <= IDLE;
            rlo   <= '0;
        end else begin
            state <= state_next;
            if (capture_lo) begin
                rlo <= irdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: word-array memory model plus a scoreboard of expected completions.
module tb_load_store_unit;

    typedef struct {
        string       tag;
        bit          isLoad;
        logic [31:0] data;
        bit          err;
    } scoreEntry_t;

    logic        iclk = 1'b0;
    logic        irst;
    logic        ivalid;
    logic        iload;
    logic        istore;
    logic [2:0]  ifunct3;
    logic [31:0] iaddr;
    logic [31:0] iwdata;
    logic        ostall;
    logic        odone;
    logic        oerr;
    logic [31:0] odata;
    logic [31:0] opos;
    logic        owen;
    logic [1:0]  obe;
    logic [31:0] owdata;
    logic [31:0] irdata;

    logic [31:0] mem [0:63] = '{default: 32'h0};

    scoreEntry_t scoreboard[$];
    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    // Free-running clock.
    always #5 iclk = ~iclk;

    load_store_unit #(.MP_WIDTH(32)) dut (
        .iclk    (iclk),
        .irst    (irst),
        .ivalid  (ivalid),
        .iload   (iload),
        .istore  (istore),
        .ifunct3 (ifunct3),
        .iaddr   (iaddr),
        .iwdata  (iwdata),
        .ostall  (ostall),
        .odone   (odone),
        .oerr    (oerr),
        .odata   (odata),
        .opos    (opos),
        .owen    (owen),
        .obe     (obe),
        .owdata  (owdata),
        .irdata  (irdata)
    );

    // Memory read is combinational from the position; only address bits [7:2] are decoded.
    always_comb irdata = mem[opos[7:2]];

    // Memory write: byte, half or word placed at the position's byte offset.
    always @(posedge iclk) begin
        if (owen) begin
            case (obe)
                2'b00:   mem[opos[7:2]][8*opos[1:0] +: 8] <= owdata[7:0];
                2'b01:   mem[opos[7:2]][8*opos[1:0] +: 16] <= owdata[15:0];
                default: mem[opos[7:2]] <= owdata;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expData, input bit expErr, input int expCycles);
        int          cyc;
        bit          done;
        bit          active;
        logic [31:0] expPos;
        scoreEntry_t e;
        scoreboard.push_back('{tag, ld && !st, expData, expErr});
        ivalid  = 1'b1;
        iload   = ld;
        istore  = st;
        ifunct3 = f3;
        iaddr   = addr;
        iwdata  = wdata;
        cyc     = 0;
        done    = 1'b0;
        active  = (ld || st) && !expErr;
        while (!done && cyc < 4) begin
            cyc++;
            @(negedge iclk);
            if (cyc == 1) begin
                checkOutput({tag, "_stall"}, 32'(ostall), 32'(expCycles == 2));
            end
            if (active) begin
                if (cyc == 1) begin
                    expPos = (expCycles == 2) ? {addr[31:2], 2'b00} : addr;
                end else begin
                    expPos = {addr[31:2] + 30'd1, 2'b00};
                end
                checkOutput({tag, "_pos"}, opos, expPos);
            end
            checkOutput({tag, "_wen"}, 32'(owen), 32'(st && !expErr));
            if (st && !expErr) begin
                checkOutput({tag, "_be"}, 32'(obe), (expCycles == 2) ? 32'd2 : 32'(f3[1:0]));
            end
            if (odone) begin
                done = 1'b1;
                if (scoreboard.size() == 0) begin
                    checkOutput({tag, "_sbempty"}, 32'd1, 32'd0);
                end else begin
                    e = scoreboard.pop_front();
                    if (e.isLoad) begin
                        checkOutput({e.tag, "_data"}, odata, e.data);
                    end
                    checkOutput({e.tag, "_err"}, 32'(oerr), 32'(e.err));
                end
            end
            @(posedge iclk);
            #1;
        end
        if (!done) begin
            checkOutput({tag, "_timeout"}, 32'(done), 32'd1);
            void'(scoreboard.pop_front());
        end
        checkOutput({tag, "_cycles"}, 32'(cyc), 32'(expCycles));
        ivalid = 1'b0;
        iload  = 1'b0;
        istore = 1'b0;
    endtask

    // Main stimulus sequence.
    initial begin
        irst    = 1'b1;
        ivalid  = 1'b0;
        iload   = 1'b0;
        istore  = 1'b0;
        ifunct3 = 3'b000;
        iaddr   = 32'h0;
        iwdata  = 32'h0;
        repeat (2) @(posedge iclk);
        @(negedge iclk);
        checkOutput("rst_stall", 32'(ostall), 32'd0);
        checkOutput("rst_done", 32'(odone), 32'd0);
        checkOutput("rst_wen", 32'(owen), 32'd0);
        checkOutput("rst_pos", opos, 32'h0);
        checkOutput("rst_data", odata, 32'h0);
        @(posedge iclk);
        #1;
        irst = 1'b0;

        // Aligned word store, then byte/half loads out of it.
        applyStimulus("sw10",  0, 1, F_W,  32'h10, 32'hDEADBEEF, 32'h0,        0, 1);
        applyStimulus("lb13",  1, 0, F_B,  32'h13, 32'h0,        32'hFFFFFFDE, 0, 1);
        applyStimulus("lbu13", 1, 0, F_BU, 32'h13, 32'h0,        32'h000000DE, 0, 1);
        applyStimulus("lh12",  1, 0, F_H,  32'h12, 32'h0,        32'hFFFFDEAD, 0, 1);
        applyStimulus("lhu10", 1, 0, F_HU, 32'h10, 32'h0,        32'h0000BEEF, 0, 1);
        applyStimulus("lw10",  1, 0, F_W,  32'h10, 32'h0,        32'hDEADBEEF, 0, 1);

        // Aligned half store over a zero word.
        applyStimulus("sh22",  0, 1, F_H,  32'h22, 32'h00001234, 32'h0, 0, 1);
        checkOutput("mem20", mem[8], 32'h12340000);

        // Spanning word store and load.
        applyStimulus("sw40",  0, 1, F_W,  32'h40, 32'h11111111, 32'h0, 0, 1);
        applyStimulus("sw44",  0, 1, F_W,  32'h44, 32'h22222222, 32'h0, 0, 1);
        applyStimulus("sw41",  0, 1, F_W,  32'h41, 32'hAABBCCDD, 32'h0, 0, 2);
        checkOutput("mem40", mem[16], 32'hBBCCDD11);
        checkOutput("mem44", mem[17], 32'h222222AA);
        applyStimulus("lw41",  1, 0, F_W,  32'h41, 32'h0, 32'hAABBCCDD, 0, 2);

        // Spanning half store and loads.
        applyStimulus("sh53",  0, 1, F_H,  32'h53, 32'h0000BEEF, 32'h0, 0, 2);
        checkOutput("mem50", mem[20], 32'hEF000000);
        checkOutput("mem54", mem[21], 32'h000000BE);
        applyStimulus("lh53",  1, 0, F_H,  32'h53, 32'h0, 32'hFFFFBEEF, 0, 2);
        applyStimulus("lhu53", 1, 0, F_HU, 32'h53, 32'h0, 32'h0000BEEF, 0, 2);

        // Top-of-address-space wrap: top word aliases index 63, word 0 is index 0.
        applyStimulus("swfc",  0, 1, F_W,  32'hFC, 32'hA1B2C3D4, 32'h0, 0, 1);
        applyStimulus("sw00",  0, 1, F_W,  32'h00, 32'h55667788, 32'h0, 0, 1);
        applyStimulus("lwtop", 1, 0, F_W,  32'hFFFFFFFE, 32'h0, 32'h7788A1B2, 0, 2);

        // Illegal store size and a request with neither load nor store.
        applyStimulus("sbad",  0, 1, F_BU, 32'h30, 32'hFFFFFFFF, 32'h0, 1, 1);
        checkOutput("mem30", mem[12], 32'h0);
        applyStimulus("lbad",  1, 0, 3'b011, 32'h30, 32'h0, 32'h0, 1, 1);
        applyStimulus("noop",  0, 0, F_W,  32'h30, 32'h0, 32'h0, 0, 1);

        // Reset during the second cycle of a spanning store.
        applyStimulus("sw60",  0, 1, F_W,  32'h60, 32'h33333333, 32'h0, 0, 1);
        applyStimulus("sw64",  0, 1, F_W,  32'h64, 32'h44444444, 32'h0, 0, 1);
        ivalid  = 1'b1;
        istore  = 1'b1;
        ifunct3 = F_W;
        iaddr   = 32'h62;
        iwdata  = 32'hAABBCCDD;
        @(negedge iclk);
        checkOutput("rsplit_stall1", 32'(ostall), 32'd1);
        checkOutput("rsplit_wen1", 32'(owen), 32'd1);
        @(posedge iclk);
        #1;
        irst = 1'b1;
        @(negedge iclk);
        checkOutput("rsplit_wen2", 32'(owen), 32'd0);
        @(posedge iclk);
        #1;
        irst   = 1'b0;
        ivalid = 1'b0;
        istore = 1'b0;
        @(negedge iclk);
        checkOutput("rsplit_idle_done", 32'(odone), 32'd0);
        checkOutput("rsplit_idle_stall", 32'(ostall), 32'd0);
        checkOutput("rsplit_idle_pos", opos, 32'h0);
        checkOutput("mem60", mem[24], 32'hCCDD3333);
        checkOutput("mem64", mem[25], 32'h44444444);
        @(posedge iclk);
        #1;

        checkOutput("sb_drained", 32'(scoreboard.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage load/store unit that sits directly upstream of the data memory.
- Decodes the RISC-V load/store size from funct3 and drives the memory's position, write-enable, byte-enable code and write data.
- Extracts and sign- or zero-extends load results from the word the memory returns.
- Splits any access that spans two memory words into a two-cycle sequence and stalls the pipeline for one cycle. Stores use read-merge-write; loads use capture-then-combine.

Parameters:
- MP_WIDTH, 32, address/data width. Only 32 is supported; byte-lane logic is fixed at 4 lanes.

Ports:
- iclk  in  1  clock, rising edge
- irst  in  1  synchronous reset, active-high
- ivalid  in  1  memory access requested this cycle
- iload  in  1  access is a load
- istore  in  1  access is a store; takes priority if iload is also high
- ifunct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- iaddr  in  MP_WIDTH  byte address
- iwdata  in  MP_WIDTH  store data, LSB-aligned
- ostall  out  1  pipeline must hold all inputs stable next cycle
- odone  out  1  access completes this cycle
- oerr  out  1  illegal funct3 for the requested op
- odata  out  MP_WIDTH  extended load result, valid when odone and the op is a load
- opos  out  MP_WIDTH  memory position
- owen  out  1  memory write enable
- obe  out  2  memory size code: 00 byte, 01 half, 10 word
- owdata  out  MP_WIDTH  memory write data
- irdata  in  MP_WIDTH  memory read data; combinational from opos

Behaviour:
- State: IDLE, SECOND. Capture register rlo is 32 bits.
- Reset (irst=1 at the edge): state is IDLE, rlo is 0. Outputs are combinational from state and inputs. In IDLE with ivalid=0, all outputs are 0.
- Byte order is little-endian. off = iaddr[1:0]; size n = 1, 2 or 4.
- Span condition: (n=2 and off=3) or (n=4 and off!=0). Byte accesses never span.
- Illegal funct3: store with funct3 not in {000, 001, 010}, or load with funct3 not in {000, 001, 010, 100, 101}.
  - In IDLE with ivalid: oerr=1, odone=1, owen=0, odata=0, no state change.
- Non-spanning access in IDLE (single cycle, no stall; odone=1, ostall=0):
  - Store: opos=iaddr, owen=1, obe=size code, owdata=iwdata.
  - Load: opos=iaddr, owen=0. odata = irdata bytes off..off+n-1, sign-extended (B, H) or zero-extended (BU, HU).
- Spanning access, cycle 1 (IDLE):
  - Outputs: ostall=1, odone=0, opos={iaddr[31:2],2'b00}.
  - Store: owen=1, obe=10. owdata = irdata with bytes off..3 replaced by iwdata bytes 0..3-off.
  - Load: owen=0; rlo <= irdata.
  - Next state: SECOND.
- Spanning access, cycle 2 (SECOND):
  - Outputs: ostall=0, odone=1, opos={iaddr[31:2]+1,2'b00}, computed modulo 2^MP_WIDTH so the top word wraps to word 0.
  - Store: owen=1, obe=10. owdata = irdata with bytes 0..off+n-5 replaced by the remaining iwdata bytes.
  - Load: odata = bytes off..3 of rlo concatenated with bytes 0..off+n-5 of irdata, then extended per funct3.
  - Next state: IDLE.
- The unit never issues obe=01 with opos[1:0]=3, and never issues obe=10 with opos[1:0]!=0.
- ivalid deasserted while in SECOND: protocol violation. The unit still completes cycle 2 using the current inputs.
- irst=1 while in SECOND: the cycle-2 memory write is suppressed (owen=0 that cycle) and state returns to IDLE. The cycle-1 partial store stays committed.
- iload=istore=0 with ivalid=1: no access; odone=1, owen=0.

Test Plan:
- Aligned store then load: SW 0xDEADBEEF @0x10; LB @0x13 -> odata 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD. All complete with odone=1 and ostall=0.
- Aligned half store: SH 0x1234 @0x22 over word 0 -> word 0x20 reads 0x12340000; obe=01, opos=0x22.
- Spanning word store: words @0x40=0x11111111 and @0x44=0x22222222; SW 0xAABBCCDD @0x41 -> cycle 1 ostall=1, word @0x40=0xBBCCDD11; cycle 2 odone=1, word @0x44=0x222222AA. Then LW @0x41 -> two cycles, odata 0xAABBCCDD.
- Spanning half: SH 0xBEEF @0x53 -> word @0x50 byte3=0xEF, word @0x54 byte0=0xBE; LH @0x53 -> 0xFFFFBEEF; LHU -> 0x0000BEEF.
- Top-address wrap: LW @0xFFFFFFFE -> cycle 2 opos=0x00000000; result combines bytes 2,3 of the top word with bytes 0,1 of word 0.
- Reset mid-split and illegal op: assert irst during SECOND of a spanning SW -> owen=0 that cycle, state IDLE next cycle, and only the first word is modified. Store with funct3=100 -> oerr=1, odone=1, owen=0.
